// File: rtl/carry_lookahead_adder.sv
// Registered N-bit two-level carry-lookahead adder (S = A + B + Cin, one cycle latency).
// Define CLA_OVERFLOW_EN to add the registered signed-overflow output V.
module carry_lookahead_adder #(
  parameter int unsigned N     = 4,
  parameter int unsigned GROUP = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic         out_valid,
  output logic [N-1:0] S,
  output logic         Cout
`ifdef CLA_OVERFLOW_EN
  ,
  output logic         V
`endif
);

  localparam int unsigned NG = (N + GROUP - 1) / GROUP;
  localparam int unsigned W  = NG * GROUP;

  logic [N-1:0]  w_g;
  logic [N-1:0]  w_p;
  logic [W-1:0]  w_gx;
  logic [W-1:0]  w_px;
  logic [NG-1:0] w_gg;
  logic [NG-1:0] w_gp;
  logic [NG:0]   w_gc;
  logic [W:0]    w_cx;
  logic [N-1:0]  w_s;

  logic          r_valid;
  logic [N-1:0]  r_s;
  logic          r_cout;

  assign w_g = A & B;
  assign w_p = A ^ B;

  // Pad a partial last group with transparent bits (g=0, p=1) so carries pass through unchanged.
  always_comb begin : pad_gp
    w_gx          = '0;
    w_px          = '1;
    w_gx[N-1:0]   = w_g;
    w_px[N-1:0]   = w_p;
  end

  always_comb begin : group_gen_prop
    logic t;
    t    = 1'b0;
    w_gg = '0;
    w_gp = '1;
    for (int unsigned gi = 0; gi < NG; gi++) begin
      for (int unsigned k = 0; k < GROUP; k++) begin
        t = w_gx[gi*GROUP + k];
        for (int unsigned m = k + 1; m < GROUP; m++) begin
          t = t & w_px[gi*GROUP + m];
        end
        w_gg[gi] = w_gg[gi] | t;
        w_gp[gi] = w_gp[gi] & w_px[gi*GROUP + k];
      end
    end
  end

  // Second level: every group carry-in in fully expanded form from GG/GP and Cin.
  always_comb begin : group_carry
    logic t;
    logic acc;
    t    = 1'b0;
    acc  = 1'b0;
    w_gc = '0;
    w_gc[0] = Cin;
    for (int unsigned gi = 0; gi < NG; gi++) begin
      acc = Cin;
      for (int unsigned k = 0; k < gi + 1; k++) begin
        acc = acc & w_gp[k];
      end
      for (int unsigned k = 0; k < gi + 1; k++) begin
        t = w_gg[k];
        for (int unsigned m = k + 1; m < gi + 1; m++) begin
          t = t & w_gp[m];
        end
        acc = acc | t;
      end
      w_gc[gi+1] = acc;
    end
  end

  // First level: bit carries inside each group, expanded from that group's carry-in.
  always_comb begin : bit_carry
    logic t;
    logic acc;
    int unsigned base;
    t    = 1'b0;
    acc  = 1'b0;
    base = 0;
    w_cx = '0;
    for (int unsigned gi = 0; gi < NG; gi++) begin
      base       = gi * GROUP;
      w_cx[base] = w_gc[gi];
      for (int unsigned j = 0; j + 1 < GROUP; j++) begin
        acc = w_gc[gi];
        for (int unsigned m = 0; m < j + 1; m++) begin
          acc = acc & w_px[base + m];
        end
        for (int unsigned k = 0; k < j + 1; k++) begin
          t = w_gx[base + k];
          for (int unsigned m = k + 1; m < j + 1; m++) begin
            t = t & w_px[base + m];
          end
          acc = acc | t;
        end
        w_cx[base + j + 1] = acc;
      end
    end
    w_cx[W] = w_gc[NG];
  end

  assign w_s = w_p ^ w_cx[N-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_s    <= w_s;
        r_cout <= w_cx[N];
      end
    end
  end

  assign out_valid = r_valid;
  assign S         = r_s;
  assign Cout      = r_cout;

`ifdef CLA_OVERFLOW_EN
  logic r_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= 1'b0;
    end else if (in_valid) begin
      r_v <= w_cx[N-1] ^ w_cx[N];
    end
  end

  assign V = r_v;
`endif

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Scoreboard bench for carry_lookahead_adder: an N=4 instance plus an N=8/GROUP=3 instance
// (partial last group) sharing clock, reset and in_valid.
module tb_carry_lookahead_adder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] A, B;
  logic       Cin;
  logic [7:0] A8, B8;
  logic       Cin8;
  logic       out_valid, out_valid8;
  logic [3:0] S;
  logic [7:0] S8;
  logic       Cout, Cout8;
`ifdef CLA_OVERFLOW_EN
  logic       V, V8;
`endif

  typedef struct packed {
    logic       vld;
    logic [3:0] s;
    logic       c;
    logic       v;
    logic [7:0] s8;
    logic       c8;
    logic       v8;
  } exp_t;

  exp_t q[$];
  int   tests;
  int   fails;

  logic [3:0] m_s;
  logic       m_c, m_v;
  logic [7:0] m_s8;
  logic       m_c8, m_v8;

  carry_lookahead_adder #(.N(4), .GROUP(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(A), .B(B), .Cin(Cin),
    .out_valid(out_valid), .S(S), .Cout(Cout)
`ifdef CLA_OVERFLOW_EN
    , .V(V)
`endif
  );

  carry_lookahead_adder #(.N(8), .GROUP(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(A8), .B(B8), .Cin(Cin8),
    .out_valid(out_valid8), .S(S8), .Cout(Cout8)
`ifdef CLA_OVERFLOW_EN
    , .V(V8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_s = '0; m_c = 1'b0; m_v = 1'b0;
    m_s8 = '0; m_c8 = 1'b0; m_v8 = 1'b0;
    q.delete();
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic c,
                       input logic [7:0] a8, input logic [7:0] b8, input logic c8);
    exp_t e;
    @(negedge clk);
    in_valid = v; A = a; B = b; Cin = c; A8 = a8; B8 = b8; Cin8 = c8;
    if (v) begin
      {m_c, m_s}   = 5'(a) + 5'(b) + 5'(c);
      m_v          = (a[3] == b[3]) && (m_s[3] != a[3]);
      {m_c8, m_s8} = 9'(a8) + 9'(b8) + 9'(c8);
      m_v8         = (a8[7] == b8[7]) && (m_s8[7] != a8[7]);
    end
    e.vld = v; e.s = m_s; e.c = m_c; e.v = m_v;
    e.s8 = m_s8; e.c8 = m_c8; e.v8 = m_v8;
    q.push_back(e);
  endtask

  task automatic check_step();
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = q.pop_front();
      cmp("out_valid", 8'(out_valid), 8'(e.vld));
      cmp("S", 8'(S), 8'(e.s));
      cmp("Cout", 8'(Cout), 8'(e.c));
      cmp("out_valid8", 8'(out_valid8), 8'(e.vld));
      cmp("S8", S8, e.s8);
      cmp("Cout8", 8'(Cout8), 8'(e.c8));
`ifdef CLA_OVERFLOW_EN
      cmp("V", 8'(V), 8'(e.v));
      cmp("V8", 8'(V8), 8'(e.v8));
`endif
    end
  endtask

  task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b, input logic c,
                      input logic [7:0] a8, input logic [7:0] b8, input logic c8);
    drive(v, a, b, c, a8, b8, c8);
    check_step();
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_valid"}, 8'(out_valid), 8'h00);
    cmp({tag, "_S"}, 8'(S), 8'h00);
    cmp({tag, "_Cout"}, 8'(Cout), 8'h00);
    cmp({tag, "_valid8"}, 8'(out_valid8), 8'h00);
    cmp({tag, "_S8"}, S8, 8'h00);
    cmp({tag, "_Cout8"}, 8'(Cout8), 8'h00);
`ifdef CLA_OVERFLOW_EN
    cmp({tag, "_V"}, 8'(V), 8'h00);
    cmp({tag, "_V8"}, 8'(V8), 8'h00);
`endif
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; A8 = '0; B8 = '0; Cin8 = 1'b0;
    model_reset();

    // Reset held with random traffic
    repeat (4) begin
      @(negedge clk);
      in_valid = 1'($urandom); A = 4'($urandom); B = 4'($urandom); Cin = 1'($urandom);
      A8 = 8'($urandom); B8 = 8'($urandom); Cin8 = 1'($urandom);
    end
    @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    model_reset();

    step(1'b1, 4'd0, 4'd0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Diagonal sweep A=B=k
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 4'(k), 4'(k), 1'b0, 8'(k * 17), 8'(k * 3), 1'b0);
    end

    // All-ones plus carry-in, and carries crossing group boundaries
    step(1'b1, 4'hF, 4'hF, 1'b1, 8'hFF, 8'h00, 1'b1);
    step(1'b1, 4'h0, 4'h0, 1'b0, 8'h0F, 8'h01, 1'b0);

    // Hold on idle, including X inputs while in_valid=0
    step(1'b1, 4'd7, 4'd8, 1'b1, 8'h80, 8'h80, 1'b0);
    step(1'b0, 4'd3, 4'd3, 1'b0, 8'h03, 8'h03, 1'b0);
    step(1'b0, 4'bxxxx, 4'bxxxx, 1'bx, 8'hxx, 8'hxx, 1'bx);

    // Signed overflow cases
    step(1'b1, 4'd7, 4'd1, 1'b0, 8'h7F, 8'h01, 1'b0);
    step(1'b1, 4'd8, 4'd8, 1'b0, 8'h80, 8'hFF, 1'b0);
    step(1'b1, 4'd3, 4'd2, 1'b0, 8'h03, 8'h02, 1'b0);

    // Async reset between edges with a valid beat presented
    @(negedge clk);
    in_valid = 1'b1; A = 4'd9; B = 4'd9; Cin = 1'b0; A8 = 8'h99; B8 = 8'h99; Cin8 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    @(posedge clk);
    #1;
    check_zero("midrst_edge");
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    model_reset();

    // Exhaustive N=4 sweep, random N=8 operands, occasional idle beats
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          step(1'b1, 4'(a), 4'(b), 1'(c), 8'($urandom), 8'($urandom), 1'($urandom));
          if (((a + b + c) % 13) == 0) begin
            step(1'b0, 4'($urandom), 4'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
